// File: rtl/rgb_stream_packer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | rgb_stream_packer                                                         |
// | Packs 24-bit RGB pixels into 32-bit AXI4-Stream words (4 pixels/3 words). |
// | Optional: RGB_PACKER_EOL_FLUSH_EN pads and terminates misaligned lines.   |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module rgb_stream_packer #(
  parameter int DATA_W = 32,
  parameter int PIX_W  = 24
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic [7:0]          r,
  input  logic [7:0]          g,
  input  logic [7:0]          b,
  input  logic                valid,
  input  logic                sof,
  input  logic                eol,
  output logic                in_stream_ready,
  output logic [DATA_W-1:0]   out_stream_tdata,
  output logic [DATA_W/8-1:0] out_stream_tkeep,
  output logic                out_stream_tlast,
  output logic                out_stream_tuser,
  output logic                out_stream_tvalid,
  input  logic                out_stream_tready,
  output logic                align_err
);

  logic [PIX_W-1:0] pix;
  logic [1:0]       ph, ph_n, eff_ph;
  logic [23:0]      res, res_n;
  logic             pend_user;
  logic             out_free, accept, load, err_set;
  logic [31:0]      word;
  logic [3:0]       keep;
  logic             last, user;
  logic             in_flush;
  logic [3:0]       flush_keep;

  assign pix      = {r, g, b};
  assign out_free = !out_stream_tvalid || out_stream_tready;
  assign accept   = valid && in_stream_ready;
  assign eff_ph   = sof ? 2'd0 : ph;
  assign user     = pend_user || (accept && sof);

`ifdef RGB_PACKER_EOL_FLUSH_EN
  typedef enum logic [0:0] {RUN = 1'b0, FLUSH = 1'b1} state_t;
  state_t     state, state_n;
  logic [3:0] fkeep, fkeep_n;

  assign in_stream_ready = !areset && (state == RUN) && out_free;
  assign in_flush        = (state == FLUSH);
  assign flush_keep      = fkeep;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= RUN;
      fkeep <= 4'h0;
    end else begin
      state <= state_n;
      fkeep <= fkeep_n;
    end
  end

  // A misaligned eol parks the padded residue; the flush word goes out next.
  always_comb begin
    state_n = state;
    fkeep_n = fkeep;
    if (state == FLUSH) begin
      if (out_free) state_n = RUN;
    end else if (accept && eol && eff_ph != 2'd3) begin
      state_n = FLUSH;
      case (eff_ph)
        2'd0:    fkeep_n = 4'h7;
        2'd1:    fkeep_n = 4'h3;
        default: fkeep_n = 4'h1;
      endcase
    end
  end
`else
  assign in_stream_ready = !areset && out_free;
  assign in_flush        = 1'b0;
  assign flush_keep      = 4'h0;
`endif

  // Residue is kept zero-extended so the flush word needs no extra masking.
  always_comb begin
    load    = 1'b0;
    word    = 32'h0;
    keep    = 4'hF;
    last    = 1'b0;
    ph_n    = ph;
    res_n   = res;
    err_set = 1'b0;
    if (in_flush) begin
      if (out_free) begin
        load  = 1'b1;
        word  = {8'h00, res};
        keep  = flush_keep;
        last  = 1'b1;
        res_n = 24'h0;
        ph_n  = 2'd0;
      end
    end else if (accept) begin
      err_set = sof && (ph != 2'd0);
      case (eff_ph)
        2'd0: begin
          res_n = pix;
          ph_n  = 2'd1;
        end
        2'd1: begin
          load  = 1'b1;
          word  = {pix[7:0], res};
          res_n = {8'h00, pix[23:8]};
          ph_n  = 2'd2;
        end
        2'd2: begin
          load  = 1'b1;
          word  = {pix[15:0], res[15:0]};
          res_n = {16'h0000, pix[23:16]};
          ph_n  = 2'd3;
        end
        default: begin
          load  = 1'b1;
          word  = {pix, res[7:0]};
          res_n = 24'h0;
          ph_n  = 2'd0;
          last  = eol;
        end
      endcase
      if (eol && eff_ph != 2'd3) begin
`ifdef RGB_PACKER_EOL_FLUSH_EN
        ph_n = 2'd0;
`else
        err_set = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      ph                <= 2'd0;
      res               <= 24'h0;
      pend_user         <= 1'b0;
      align_err         <= 1'b0;
      out_stream_tvalid <= 1'b0;
      out_stream_tdata  <= '0;
      out_stream_tkeep  <= '0;
      out_stream_tlast  <= 1'b0;
      out_stream_tuser  <= 1'b0;
    end else begin
      ph  <= ph_n;
      res <= res_n;
      if (err_set) align_err <= 1'b1;
      if (load) begin
        out_stream_tvalid <= 1'b1;
        out_stream_tdata  <= word;
        out_stream_tkeep  <= keep;
        out_stream_tlast  <= last;
        out_stream_tuser  <= user;
        pend_user         <= 1'b0;
      end else begin
        if (out_stream_tready) out_stream_tvalid <= 1'b0;
        if (accept && sof)     pend_user <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rgb_stream_packer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_rgb_stream_packer                                                      |
// | Directed self-checking bench for rgb_stream_packer.                       |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_rgb_stream_packer;

  logic        aclk = 1'b0;
  logic        areset;
  logic [7:0]  r, g, b;
  logic        valid, sof, eol;
  logic        in_stream_ready;
  logic [31:0] out_stream_tdata;
  logic [3:0]  out_stream_tkeep;
  logic        out_stream_tlast, out_stream_tuser, out_stream_tvalid;
  logic        out_stream_tready;
  logic        align_err;

  int tests = 0;
  int fails = 0;
  logic [37:0] q[$];

  always #5 aclk = ~aclk;

  rgb_stream_packer dut (
    .aclk              (aclk),
    .areset            (areset),
    .r                 (r),
    .g                 (g),
    .b                 (b),
    .valid             (valid),
    .sof               (sof),
    .eol               (eol),
    .in_stream_ready   (in_stream_ready),
    .out_stream_tdata  (out_stream_tdata),
    .out_stream_tkeep  (out_stream_tkeep),
    .out_stream_tlast  (out_stream_tlast),
    .out_stream_tuser  (out_stream_tuser),
    .out_stream_tvalid (out_stream_tvalid),
    .out_stream_tready (out_stream_tready),
    .align_err         (align_err)
  );

  // Words that will transfer on the coming edge, as {tuser,tlast,tkeep,tdata}.
  always @(negedge aclk) begin
    if (!areset && out_stream_tvalid && out_stream_tready)
      q.push_back({out_stream_tuser, out_stream_tlast, out_stream_tkeep, out_stream_tdata});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic align();
    @(posedge aclk);
    #1;
  endtask

  // Call at posedge+1; returns at posedge+1 after the pixel is accepted.
  task automatic send(input logic [23:0] p, input logic s, input logic e);
    int n;
    {r, g, b} = p;
    sof   = s;
    eol   = e;
    valid = 1'b1;
    n = 0;
    @(negedge aclk);
    while (!in_stream_ready && n < 100) begin
      n++;
      @(negedge aclk);
    end
    if (n >= 100) check("send_timeout", 64'd0, 64'd1);
    @(posedge aclk);
    #1;
    valid = 1'b0;
    sof   = 1'b0;
    eol   = 1'b0;
  endtask

  task automatic expect_word(input string tag, input int idx, input logic [31:0] d,
                             input logic [3:0] k, input logic l, input logic u);
    logic [37:0] obs;
    obs = (idx < q.size()) ? q[idx] : '1;
    check(tag, {26'h0, obs}, {26'h0, u, l, k, d});
  endtask

  initial begin
    int nlast;
    areset = 1'b1; valid = 1'b0; sof = 1'b0; eol = 1'b0;
    r = 8'h0; g = 8'h0; b = 8'h0; out_stream_tready = 1'b0;

    // Reset state
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check("rst_tvalid", {63'h0, out_stream_tvalid}, 64'd0);
    check("rst_tdata", {32'h0, out_stream_tdata}, 64'd0);
    check("rst_ready", {63'h0, in_stream_ready}, 64'd0);
    check("rst_err", {63'h0, align_err}, 64'd0);
    align();
    areset = 1'b0;
    @(negedge aclk);
    check("ready_after_rst", {63'h0, in_stream_ready}, 64'd1);

    // Basic 4-pixel pack with sof
    align();
    out_stream_tready = 1'b1;
    q.delete();
    send(24'h112233, 1'b1, 1'b0);
    send(24'h445566, 1'b0, 1'b0);
    send(24'h778899, 1'b0, 1'b0);
    send(24'hAABBCC, 1'b0, 1'b0);
    repeat (3) @(negedge aclk);
    check("t1_count", q.size(), 64'd3);
    expect_word("t1_w0", 0, 32'h66112233, 4'hF, 1'b0, 1'b1);
    expect_word("t1_w1", 1, 32'h88994455, 4'hF, 1'b0, 1'b0);
    expect_word("t1_w2", 2, 32'hAABBCC77, 4'hF, 1'b0, 1'b0);

    // Backpressure: first word held for 5 cycles
    align();
    out_stream_tready = 1'b0;
    q.delete();
    send(24'h112233, 1'b1, 1'b0);
    send(24'h445566, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check("stall_ready", {63'h0, in_stream_ready}, 64'd0);
      check("stall_tdata", {32'h0, out_stream_tdata}, 64'h66112233);
    end
    align();
    out_stream_tready = 1'b1;
    send(24'h778899, 1'b0, 1'b0);
    send(24'hAABBCC, 1'b0, 1'b0);
    repeat (3) @(negedge aclk);
    check("t2_count", q.size(), 64'd3);
    expect_word("t2_w0", 0, 32'h66112233, 4'hF, 1'b0, 1'b1);
    expect_word("t2_w1", 1, 32'h88994455, 4'hF, 1'b0, 1'b0);
    expect_word("t2_w2", 2, 32'hAABBCC77, 4'hF, 1'b0, 1'b0);

    // 640-pixel line
    align();
    q.delete();
    for (int i = 0; i < 640; i++)
      send({8'h5A, 16'(i)}, 1'b0, i == 639);
    repeat (3) @(negedge aclk);
    nlast = 0;
    foreach (q[i]) if (q[i][36]) nlast++;
    check("line_words", q.size(), 64'd480);
    check("line_tlast_cnt", nlast, 64'd1);
    check("line_tlast_end", (q.size() == 480) ? {63'h0, q[479][36]} : 64'd0, 64'd1);

`ifdef RGB_PACKER_EOL_FLUSH_EN
    // eol at ph1: flush word padded
    align();
    q.delete();
    send(24'h112233, 1'b0, 1'b0);
    send(24'h445566, 1'b0, 1'b1);
    @(negedge aclk);
    check("flush_ready_lo", {63'h0, in_stream_ready}, 64'd0);
    @(negedge aclk);
    check("flush_ready_hi", {63'h0, in_stream_ready}, 64'd1);
    repeat (2) @(negedge aclk);
    check("flush_count", q.size(), 64'd2);
    expect_word("flush_w0", 0, 32'h66112233, 4'hF, 1'b0, 1'b0);
    expect_word("flush_w1", 1, 32'h00004455, 4'h3, 1'b1, 1'b0);
`else
    // eol at ph1 ignored: residue carries on, align_err flags it
    align();
    q.delete();
    send(24'h112233, 1'b0, 1'b0);
    send(24'h445566, 1'b0, 1'b1);
    @(negedge aclk);
    check("eol_mis_err", {63'h0, align_err}, 64'd1);
    align();
    send(24'h778899, 1'b0, 1'b0);
    send(24'hAABBCC, 1'b0, 1'b0);
    repeat (3) @(negedge aclk);
    check("eol_mis_count", q.size(), 64'd3);
    expect_word("eol_mis_w0", 0, 32'h66112233, 4'hF, 1'b0, 1'b0);
    expect_word("eol_mis_w1", 1, 32'h88994455, 4'hF, 1'b0, 1'b0);
    expect_word("eol_mis_w2", 2, 32'hAABBCC77, 4'hF, 1'b0, 1'b0);
`endif

    // sof at ph2: residue dropped, align_err set
    align();
    areset = 1'b1;
    align();
    areset = 1'b0;
    q.delete();
    send(24'h010203, 1'b0, 1'b0);
    send(24'h040506, 1'b0, 1'b0);
    @(negedge aclk);
    check("sof_err_before", {63'h0, align_err}, 64'd0);
    align();
    send(24'h112233, 1'b1, 1'b0);
    send(24'h445566, 1'b0, 1'b0);
    send(24'h778899, 1'b0, 1'b0);
    send(24'hAABBCC, 1'b0, 1'b0);
    repeat (3) @(negedge aclk);
    check("sof_err_after", {63'h0, align_err}, 64'd1);
    check("sof_count", q.size(), 64'd4);
    expect_word("sof_w0", 0, 32'h06010203, 4'hF, 1'b0, 1'b0);
    expect_word("sof_w1", 1, 32'h66112233, 4'hF, 1'b0, 1'b1);
    expect_word("sof_w2", 2, 32'h88994455, 4'hF, 1'b0, 1'b0);
    expect_word("sof_w3", 3, 32'hAABBCC77, 4'hF, 1'b0, 1'b0);

    // Reset while a word is stalled
    align();
    out_stream_tready = 1'b0;
    q.delete();
    send(24'h010203, 1'b0, 1'b0);
    send(24'h040506, 1'b0, 1'b0);
    @(negedge aclk);
    check("hold_tvalid", {63'h0, out_stream_tvalid}, 64'd1);
    align();
    areset = 1'b1;
    @(negedge aclk);
    @(negedge aclk);
    check("mid_rst_tvalid", {63'h0, out_stream_tvalid}, 64'd0);
    check("mid_rst_outs", {25'h0, out_stream_tuser, out_stream_tlast, out_stream_tkeep,
                           out_stream_tdata, align_err}, 64'd0);
    align();
    areset = 1'b0;
    out_stream_tready = 1'b1;
    q.delete();
    send(24'h112233, 1'b1, 1'b0);
    send(24'h445566, 1'b0, 1'b0);
    send(24'h778899, 1'b0, 1'b0);
    send(24'hAABBCC, 1'b0, 1'b0);
    repeat (3) @(negedge aclk);
    check("post_rst_count", q.size(), 64'd3);
    expect_word("post_rst_w0", 0, 32'h66112233, 4'hF, 1'b0, 1'b1);
    expect_word("post_rst_w1", 1, 32'h88994455, 4'hF, 1'b0, 1'b0);
    expect_word("post_rst_w2", 2, 32'hAABBCC77, 4'hF, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
